pe_row_fifo: RTL and testbench
==============================

# pe_row_fifo

Row-tagged buffer between the row serializer and the PE array. It captures the Iw-lane words the serializer emits, HOUT/Iw consecutive words per output row. Each word is tagged with its rowID and with first/last-of-row flags. Words are replayed to the PE array through a registered read port. Occupancy and "room for a whole row" status let the upstream controller hold off issuing the next row.

## Interface
Parameters:
- DATA_WIDTH, 8, lane width
- HOUT, 56, pixels per row; HOUT%Iw==0
- Iw, 7, lanes per word
- ROWID_WIDTH, 6, row tag width
- DEPTH, 32, words stored; power of 2, ≥ HOUT/Iw
- Derived: WPR = HOUT/Iw (words per row); AW = log2(DEPTH)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- pe_buffer_fifo_we  in  1  write strobe, one word per high cycle
- rowID_r  in  ROWID_WIDTH  row tag, stable while a row is written
- pe_buffer_input  in  DATA_WIDTH × [Iw]  write word (unpacked array)
- rd_en  in  1  read request
- dout  out  DATA_WIDTH × [Iw]  read word
- dout_valid  out  1  dout/tags valid this cycle
- dout_rowID  out  ROWID_WIDTH  tag of dout
- dout_first / dout_last  out  1 each  word index 0 / WPR-1 of its row
- empty / full  out  1 each
- count  out  AW+1  words stored
- rows_avail  out  AW+1  complete rows stored (last word written, not yet read)
- row_space  out  1  DEPTH-count ≥ WPR
- overflow  out  1  sticky: a write was dropped

## Operation
- Storage: circular array of DEPTH entries {data, rowID, first, last}; wr_ptr and rd_ptr are AW bits and wrap modulo DEPTH; count tracks occupancy.
- Write-side FSM:
  - W_IDLE: a write with we=1 accepted → store the word with first=1, latch rowID_r, wcnt=1. Next state is W_ROW, or stays W_IDLE if WPR==1; in that case last=1 as well.
  - W_ROW: each accepted write stores the latched rowID with first=0. wcnt increments. The word with wcnt==WPR-1 gets last=1, and the FSM returns to W_IDLE with wcnt=0.
  - Gaps in we are allowed; the FSM holds state.
- Write accepted iff we=1 and full=0 at the start of the cycle. A same-cycle read does not free space for that write.
- Write with full=1: word dropped, pointers/FSM/wcnt unchanged, overflow←1. overflow clears only on reset.
- Read accepted iff rd_en=1 and empty=0.
  - The entry at rd_ptr is registered onto dout/tags; dout_valid=1 on the next cycle; rd_ptr++.
  - rd_en while empty: ignored; dout_valid=0 next cycle.
  - dout and tags hold their last value when dout_valid=0.
- count: +1 on accepted write only, −1 on accepted read only, unchanged when both occur.
- rows_avail: +1 on accepted write with last=1, −1 on accepted read of an entry with last=1, unchanged when both occur.
- Status is combinational from registered state:
  - empty = (count==0)
  - full = (count==DEPTH)
  - row_space = (DEPTH−count ≥ WPR)

## Timing
- Reset state (asynchronous):
  - pointers, count, rows_avail, wcnt = 0; FSM = W_IDLE
  - dout lanes, dout_rowID, dout_first, dout_last, dout_valid, overflow = 0
  - empty=1, full=0, row_space=1
- Write-to-status latency 1: the word written at edge n is visible in count/empty after edge n.
- Read latency 1: rd_en sampled at edge n gives dout_valid=1 during cycle n+1.
- Write-through minimum 2 cycles: write at edge n, rd_en at n+1, data at n+2. There is no bypass.
- Sustained rate: one write and one read per cycle.
- Reset asserted mid-row: partial row discarded; the next write is treated as word 0 of a new row.

## Test plan
- Reset, then write one row: WPR=8 words, rowID_r=5, lane values k*Iw+i. Then rd_en for 8 cycles → dout returns the same words in order with dout_rowID=5; dout_first only on word 0, dout_last only on word 7; rows_avail goes 0→1→0; count ends at 0 with empty=1.
- Write 4 complete rows (32 words) → full=1, row_space=0, rows_avail=4. A 33rd write is dropped and overflow=1. Reading all 32 words returns rows 0..3 intact.
- Row_space edge: count=24 → row_space=1; count=25 → row_space=0. One read at count=25 → row_space=1.
- Simultaneous read and write at count=10 for 20 cycles → count stays 10; data order preserved across the pointer wrap at 31→0.
- Write 3 words of a row, assert rstn=0 for 1 cycle, then write a full row with rowID_r=9 → exactly 8 words stored, first word has dout_first=1 and rowID 9.
- rd_en while empty → dout_valid=0; count, pointers and dout unchanged.

Source files
------------

// File: rtl/pe_row_fifo.sv
// Row-tagged word buffer between the row serializer and the PE array.
// Each stored word carries its rowID plus first/last-of-row flags; reads are registered.
module pe_row_fifo #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned HOUT        = 56,
    parameter int unsigned Iw          = 7,
    parameter int unsigned ROWID_WIDTH = 6,
    parameter int unsigned DEPTH       = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   pe_buffer_fifo_we,
    input  logic [ROWID_WIDTH-1:0] rowID_r,
    input  logic [DATA_WIDTH-1:0]  pe_buffer_input [Iw],
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  dout [Iw],
    output logic                   dout_valid,
    output logic [ROWID_WIDTH-1:0] dout_rowID,
    output logic                   dout_first,
    output logic                   dout_last,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] rows_avail,
    output logic                   row_space,
    output logic                   overflow
);

    localparam int unsigned WPR = HOUT / Iw;
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned WCW = (WPR > 1) ? $clog2(WPR) : 1;

    typedef enum logic [0:0] {StWIdle, StWRow} wstate_e;

    logic [DATA_WIDTH-1:0]  mem_data  [DEPTH][Iw];
    logic [ROWID_WIDTH-1:0] mem_rowid [DEPTH];
    logic                   mem_first [DEPTH];
    logic                   mem_last  [DEPTH];

    wstate_e                state_q, state_d;
    logic [WCW-1:0]         wcnt_q, wcnt_d;
    logic [ROWID_WIDTH-1:0] rowid_q, rowid_d;
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [AW:0]            count_q, count_d;
    logic [AW:0]            rows_q, rows_d;
    logic                   overflow_q;

    logic [DATA_WIDTH-1:0]  dout_q [Iw];
    logic [ROWID_WIDTH-1:0] dout_rowid_q;
    logic                   dout_first_q, dout_last_q, dout_valid_q;

    logic                   wr_acc, rd_acc;
    logic                   wr_first, wr_last;
    logic [ROWID_WIDTH-1:0] wr_rowid;
    logic                   rd_is_last;

    assign empty      = (count_q == '0);
    assign full       = (count_q == (AW+1)'(DEPTH));
    assign row_space  = (count_q <= (AW+1)'(DEPTH - WPR));
    assign wr_acc     = pe_buffer_fifo_we & ~full;
    assign rd_acc     = rd_en & ~empty;
    assign rd_is_last = mem_last[rd_ptr_q];

    // Write-side row tracker: tags each accepted word with its row and position.
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        rowid_d  = rowid_q;
        wr_first = 1'b0;
        wr_last  = 1'b0;
        wr_rowid = rowid_q;
        if (wr_acc) begin
            case (state_q)
                StWIdle: begin
                    wr_first = 1'b1;
                    wr_rowid = rowID_r;
                    rowid_d  = rowID_r;
                    if (WPR == 1) begin
                        wr_last = 1'b1;
                        wcnt_d  = '0;
                    end else begin
                        wcnt_d  = WCW'(1);
                        state_d = StWRow;
                    end
                end
                StWRow: begin
                    if (wcnt_q == WCW'(WPR - 1)) begin
                        wr_last = 1'b1;
                        wcnt_d  = '0;
                        state_d = StWIdle;
                    end else begin
                        wcnt_d = wcnt_q + WCW'(1);
                    end
                end
                default: state_d = StWIdle;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        rows_d  = rows_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        case ({wr_acc & wr_last, rd_acc & rd_is_last})
            2'b10:   rows_d = rows_q + (AW+1)'(1);
            2'b01:   rows_d = rows_q - (AW+1)'(1);
            default: rows_d = rows_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StWIdle;
            wcnt_q     <= '0;
            rowid_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rows_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rowid_q <= rowid_d;
            count_q <= count_d;
            rows_q  <= rows_d;
            if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_acc) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (pe_buffer_fifo_we && full) overflow_q <= 1'b1;
        end
    end

    // Storage array carries no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int i = 0; i < int'(Iw); i++) begin
                mem_data[wr_ptr_q][i] <= pe_buffer_input[i];
            end
            mem_rowid[wr_ptr_q] <= wr_rowid;
            mem_first[wr_ptr_q] <= wr_first;
            mem_last[wr_ptr_q]  <= wr_last;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(Iw); i++) begin
                dout_q[i] <= '0;
            end
            dout_rowid_q <= '0;
            dout_first_q <= 1'b0;
            dout_last_q  <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= rd_acc;
            if (rd_acc) begin
                for (int i = 0; i < int'(Iw); i++) begin
                    dout_q[i] <= mem_data[rd_ptr_q][i];
                end
                dout_rowid_q <= mem_rowid[rd_ptr_q];
                dout_first_q <= mem_first[rd_ptr_q];
                dout_last_q  <= rd_is_last;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_rowID = dout_rowid_q;
    assign dout_first = dout_first_q;
    assign dout_last  = dout_last_q;
    assign count      = count_q;
    assign rows_avail = rows_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_pe_row_fifo.sv
// Directed bench for pe_row_fifo: a queue-based reference model predicts every read word,
// its tags and all status outputs cycle by cycle.
module tb_pe_row_fifo;

    localparam int DW    = 8;
    localparam int IW    = 7;
    localparam int RW    = 6;
    localparam int HOUT  = 56;
    localparam int DEPTH = 32;
    localparam int WPR   = HOUT / IW;

    typedef struct packed {
        logic [63:0]   data;
        logic [RW-1:0] rid;
        logic          first;
        logic          last;
    } item_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          we = 1'b0;
    logic [RW-1:0] rid = '0;
    logic [DW-1:0] din [IW];
    logic          re = 1'b0;
    logic [DW-1:0] dout [IW];
    logic          dout_valid, dout_first, dout_last;
    logic [RW-1:0] dout_rowid;
    logic          empty, full, row_space, overflow;
    logic [5:0]    count, rows_avail;

    item_t sb[$];
    item_t last_out;
    int    total = 0;
    int    bad = 0;
    int    seq = 0;
    int    wpos = 0;
    logic [RW-1:0] lat_rid = '0;
    logic  ovf_m = 1'b0;

    pe_row_fifo #(
        .DATA_WIDTH (DW),
        .HOUT       (HOUT),
        .Iw         (IW),
        .ROWID_WIDTH(RW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .pe_buffer_fifo_we(we),
        .rowID_r          (rid),
        .pe_buffer_input  (din),
        .rd_en            (re),
        .dout             (dout),
        .dout_valid       (dout_valid),
        .dout_rowID       (dout_rowid),
        .dout_first       (dout_first),
        .dout_last        (dout_last),
        .empty            (empty),
        .full             (full),
        .count            (count),
        .rows_avail       (rows_avail),
        .row_space        (row_space),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pack(input logic [DW-1:0] a [IW]);
        logic [63:0] v = '0;
        for (int i = 0; i < IW; i++) v[i*DW +: DW] = a[i];
        return v;
    endfunction

    function automatic int rows_in_model();
        int n = 0;
        foreach (sb[i]) if (sb[i].last) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status();
        int n = sb.size();
        chk("count", 64'(count), 64'(n));
        chk("empty", 64'(empty), 64'(n == 0));
        chk("full", 64'(full), 64'(n == DEPTH));
        chk("row_space", 64'(row_space), 64'((DEPTH - n) >= WPR));
        chk("rows_avail", 64'(rows_avail), 64'(rows_in_model()));
        chk("overflow", 64'(overflow), 64'(ovf_m));
    endtask

    task automatic check_out(input string tag, input logic valid, input item_t e);
        chk({tag, "_valid"}, 64'(dout_valid), 64'(valid));
        chk({tag, "_data"}, pack(dout), e.data);
        chk({tag, "_rowid"}, 64'(dout_rowid), 64'(e.rid));
        chk({tag, "_first"}, 64'(dout_first), 64'(e.first));
        chk({tag, "_last"}, 64'(dout_last), 64'(e.last));
    endtask

    // One clock: drive inputs, advance the model, then check outputs after the edge.
    task automatic step(input logic we_i, input logic [RW-1:0] rid_i, input logic re_i);
        item_t it;
        item_t exp;
        int    n = sb.size();
        bit    wr_ok = we_i && (n < DEPTH);
        bit    rd_ok = re_i && (n > 0);
        for (int i = 0; i < IW; i++) din[i] = DW'(seq * IW + i);
        we  = we_i;
        rid = rid_i;
        re  = re_i;
        exp = '0;
        if (we_i && !wr_ok) ovf_m = 1'b1;
        if (rd_ok) exp = sb.pop_front();
        if (wr_ok) begin
            it.data  = pack(din);
            it.first = (wpos == 0);
            if (wpos == 0) lat_rid = rid_i;
            it.rid   = lat_rid;
            it.last  = (wpos == WPR - 1);
            wpos     = (wpos + 1) % WPR;
            sb.push_back(it);
            seq++;
        end
        @(posedge clk);
        #1;
        if (rd_ok) begin
            check_out("rd", 1'b1, exp);
            last_out = exp;
        end else begin
            check_out("hold", 1'b0, last_out);
        end
        chk_status();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        we   = 1'b0;
        re   = 1'b0;
        sb.delete();
        wpos     = 0;
        ovf_m    = 1'b0;
        last_out = '0;
        #1;
        check_out("rst", 1'b0, last_out);
        chk_status();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < IW; i++) din[i] = '0;
        last_out = '0;
        #2;
        do_reset();

        // One row with rowID 5, then read it back
        for (int k = 0; k < WPR; k++) step(1'b1, 6'd5, 1'b0);
        for (int k = 0; k < WPR; k++) step(1'b0, 6'd0, 1'b1);

        // Fill with four rows, one dropped write, then drain
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < WPR; k++) step(1'b1, RW'(r + 1), 1'b0);
        step(1'b1, 6'd7, 1'b0);
        for (int k = 0; k < DEPTH; k++) step(1'b0, 6'd0, 1'b1);

        // row_space boundary at 24/25 entries
        for (int k = 0; k < 25; k++) step(1'b1, RW'(10 + k / WPR), 1'b0);
        step(1'b0, 6'd0, 1'b1);
        for (int k = 0; k < 14; k++) step(1'b0, 6'd0, 1'b1);

        // Concurrent read+write at occupancy 10, wrapping the pointers
        for (int k = 0; k < 20; k++) step(1'b1, 6'd20, 1'b1);
        for (int k = 0; k < 10; k++) step(1'b0, 6'd0, 1'b1);

        // Reads while empty are ignored
        for (int k = 0; k < 3; k++) step(1'b0, 6'd0, 1'b1);

        // Partial row, reset, then a fresh row tagged 9
        step(1'b0, 6'd0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 6'd7, 1'b0);
        do_reset();
        for (int k = 0; k < WPR; k++) step(1'b1, 6'd9, 1'b0);
        for (int k = 0; k < WPR; k++) step(1'b0, 6'd0, 1'b1);
        step(1'b0, 6'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
